// File: rtl/ifu_inst_buffer.sv
// Instruction fetch buffer: first-word-fall-through FIFO of {inst, addr, pred}
// sitting between fetch and decode; a flush discards everything queued.
module ifu_inst_buffer #(
  parameter int unsigned INST_DATA_WIDTH = 32,
  parameter int unsigned INST_ADDR_WIDTH = 32,
  parameter int unsigned DEPTH           = 4,
  parameter logic [INST_DATA_WIDTH-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       fetch_valid_i,
  output logic                       fetch_ready_o,
  input  logic [INST_DATA_WIDTH-1:0] fetch_inst_i,
  input  logic [INST_ADDR_WIDTH-1:0] fetch_addr_i,
  input  logic                       fetch_pred_i,
  input  logic                       dec_ready_i,
  output logic                       inst_valid_o,
  output logic [INST_DATA_WIDTH-1:0] inst_o,
  output logic [INST_ADDR_WIDTH-1:0] inst_addr_o,
  output logic                       is_pred_branch_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  logic [INST_DATA_WIDTH-1:0] inst_q [DEPTH];
  logic [INST_ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic                       pred_q [DEPTH];

  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             empty, full, push, pop;

  assign wr_idx = wr_ptr_q[IDX_W-1:0];
  assign rd_idx = rd_ptr_q[IDX_W-1:0];

  // The extra pointer MSB separates "full" from "empty" when indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) && (wr_idx == rd_idx);

  assign fetch_ready_o = !full;
  assign inst_valid_o  = !empty;
  assign push          = fetch_valid_i && fetch_ready_o && !flush_i;
  assign pop           = inst_valid_o && dec_ready_i && !flush_i;
  assign count_o       = wr_ptr_q - rd_ptr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload storage is deliberately left unreset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_q[wr_idx] <= fetch_inst_i;
      addr_q[wr_idx] <= fetch_addr_i;
      pred_q[wr_idx] <= fetch_pred_i;
    end
  end

  assign inst_o           = empty ? NOP_INST : inst_q[rd_idx];
  assign inst_addr_o      = empty ? '0 : addr_q[rd_idx];
  assign is_pred_branch_o = empty ? 1'b0 : pred_q[rd_idx];

endmodule

// File: tb/tb_ifu_inst_buffer.sv
// Directed bench for ifu_inst_buffer with a queue scoreboard tracking the
// expected FIFO contents and head outputs cycle by cycle.
module tb_ifu_inst_buffer;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        pred;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_inst_i;
  logic [31:0] fetch_addr_i;
  logic        fetch_pred_i;
  logic        dec_ready_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        is_pred_branch_o;
  logic [2:0]  count_o;

  entry_t sb[$];
  int nAssert = 0;
  int nFail   = 0;

  ifu_inst_buffer #(
    .INST_DATA_WIDTH(32),
    .INST_ADDR_WIDTH(32),
    .DEPTH(DEPTH),
    .NOP_INST(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush_i(flush_i),
    .fetch_valid_i(fetch_valid_i),
    .fetch_ready_o(fetch_ready_o),
    .fetch_inst_i(fetch_inst_i),
    .fetch_addr_i(fetch_addr_i),
    .fetch_pred_i(fetch_pred_i),
    .dec_ready_i(dec_ready_i),
    .inst_valid_o(inst_valid_o),
    .inst_o(inst_o),
    .inst_addr_o(inst_addr_o),
    .is_pred_branch_o(is_pred_branch_o),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] instFor(input logic [31:0] addr);
    return {16'hC0DE, addr[15:0]};
  endfunction

  // Expected state after async reset, checked without any clock edge.
  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".valid"}, {31'd0, inst_valid_o}, 32'd0);
    checkOutput({tag, ".inst"},  inst_o, NOP);
    checkOutput({tag, ".addr"},  inst_addr_o, 32'd0);
    checkOutput({tag, ".pred"},  {31'd0, is_pred_branch_o}, 32'd0);
    checkOutput({tag, ".ready"}, {31'd0, fetch_ready_o}, 32'd1);
    checkOutput({tag, ".count"}, {29'd0, count_o}, 32'd0);
  endtask

  // One cycle, entered and left at a falling edge: drive inputs, compare the
  // head/status against the scoreboard, then advance the model across the edge.
  task automatic applyStimulus(input string tag, input logic valid, input logic [31:0] addr,
                               input logic pred, input logic dec, input logic flush);
    entry_t head;
    entry_t e;
    logic   expReady, expValid, doPush, doPop;
    fetch_valid_i = valid;
    fetch_addr_i  = addr;
    fetch_inst_i  = instFor(addr);
    fetch_pred_i  = pred;
    dec_ready_i   = dec;
    flush_i       = flush;
    expReady = (sb.size() < DEPTH);
    expValid = (sb.size() != 0);
    if (expValid) head = sb[0];
    else begin
      head.inst = NOP;
      head.addr = 32'd0;
      head.pred = 1'b0;
    end
    checkOutput({tag, ".valid"}, {31'd0, inst_valid_o}, {31'd0, expValid});
    checkOutput({tag, ".ready"}, {31'd0, fetch_ready_o}, {31'd0, expReady});
    checkOutput({tag, ".count"}, {29'd0, count_o}, sb.size());
    checkOutput({tag, ".inst"},  inst_o, head.inst);
    checkOutput({tag, ".addr"},  inst_addr_o, head.addr);
    checkOutput({tag, ".pred"},  {31'd0, is_pred_branch_o}, {31'd0, head.pred});
    doPush = valid && expReady && !flush;
    doPop  = expValid && dec && !flush;
    e.inst = instFor(addr);
    e.addr = addr;
    e.pred = pred;
    @(posedge clk);
    if (flush) sb.delete();
    else begin
      if (doPop)  void'(sb.pop_front());
      if (doPush) sb.push_back(e);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    flush_i = 1'b0;
    fetch_valid_i = 1'b0;
    fetch_inst_i = '0;
    fetch_addr_i = '0;
    fetch_pred_i = 1'b0;
    dec_ready_i = 1'b0;
    #2;
    checkResetValues("reset");
    @(negedge clk);
    rst = 1'b0;

    applyStimulus("idle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus("idle", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Fill with decode stalled; the fifth attempt must bounce.
    for (int k = 0; k < 4; k++)
      applyStimulus("fill", 1'b1, 32'h100 + 32'(4 * k), (k == 2), 1'b0, 1'b0);
    applyStimulus("fill5", 1'b1, 32'h110, 1'b0, 1'b0, 1'b0);
    applyStimulus("hold", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("fill.count4", {29'd0, count_o}, 32'd4);

    for (int k = 0; k < 5; k++)
      applyStimulus("drain", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    for (int k = 0; k < 20; k++)
      applyStimulus("stream", 1'b1, 32'h200 + 32'(4 * k), k[0], 1'b1, 1'b0);
    applyStimulus("streamEnd", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus("streamEnd", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    for (int k = 0; k < 3; k++)
      applyStimulus("preFlush", 1'b1, 32'h300 + 32'(4 * k), 1'b0, 1'b0, 1'b0);
    applyStimulus("flush", 1'b1, 32'h30C, 1'b1, 1'b1, 1'b1);
    checkOutput("flush.count0", {29'd0, count_o}, 32'd0);
    applyStimulus("postFlush", 1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
    applyStimulus("postFlush", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus("postFlush", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);

    // Full buffer with a pop in the same cycle: ready stays low, push ignored.
    for (int k = 0; k < 4; k++)
      applyStimulus("refill", 1'b1, 32'h500 + 32'(4 * k), (k == 1), 1'b0, 1'b0);
    applyStimulus("fullPop", 1'b1, 32'h510, 1'b0, 1'b1, 1'b0);
    applyStimulus("afterFullPop", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between edges with entries queued.
    fetch_valid_i = 1'b0;
    dec_ready_i   = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkResetValues("asyncRst");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("afterRst", 1'b1, 32'h600, 1'b1, 1'b0, 1'b0);
    applyStimulus("afterRst", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus("afterRst", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
